winner_banner: RTL and testbench
================================

Name: winner_banner

Overview:
- Parametrised, pipelined successor to the game-over text screen of the TicTacToe VGA path.
- Draws a title string ("Winner" or "Draw"), plus the winning symbol X or O, as scaled 8x16 font glyphs. Glyphs come from the shared synchronous font ROM.
- Latches the result at game end and blinks it for a programmable number of frames, then holds it steady.
- Feeds the top-level pixel mux alongside the board and menu text layers.

Parameters:
- SCALE_LOG2, 2, glyph magnification 2^SCALE_LOG2 (legal 0..2); char cell = (8<<S) x (16<<S) pixels.
- TITLE_ROW, 1, char-row index of the title.
- TITLE_COL, 3, char-column index of the first title character.
- SYM_ROW, 3, char-row index of the symbol.
- SYM_COL, 7, char-column index of the symbol.
- BLINK_FRAMES, 30, frames per blink half-period (on or off).
- BLINK_COUNT, 3, number of on/off blink cycles before steady display.
- TITLE_COLOR, 3'b010, RGB of title foreground.
- SYM_COLOR, 3'b111, RGB of symbol foreground.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  layer enable; when low, no pipeline advance and no FSM advance
- pixel_tick  in  1  one-cycle strobe per pixel
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- show  in  1  level; high while game-over screen is requested
- winner  in  2  00 none, 01 X, 10 O, 11 draw
- font_word  in  8  font ROM row data, valid one pixel_tick after rom_addr
- rom_addr  out  11  {char_code[6:0], glyph_row[3:0]} to font ROM
- text_on  out  3  {1'b0, title_on, sym_on}, aligned with text_rgb
- text_rgb  out  3  pixel colour

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous, active-high.
- Reset values: rom_addr=0, text_on=0, text_rgb=0, FSM=IDLE, all counters 0, latched winner=00.
- Advance condition "adv" = pixel_tick & ce. All pipeline registers and the FSM update only on adv.
- Geometry, with S = SCALE_LOG2:
  - ccol = pix_x >> (S+3); crow = pix_y >> (S+4).
  - glyph_row = pix_y[S+3:S]; bit_sel = pix_x[S+2:S].
- Title region: crow==TITLE_ROW and ccol in [TITLE_COL, TITLE_COL+5].
  - Character index k = ccol-TITLE_COL.
  - Winner strings: W,i,n,n,e,r (0x57,0x69,0x6E,0x6E,0x65,0x72).
  - Draw strings: D,r,a,w,space,space (0x44,0x72,0x61,0x77,0x00,0x00).
- Symbol region: crow==SYM_ROW and ccol==SYM_COL.
  - Code 0x58 for X, 0x4F for O.
  - Region disabled when the latched winner is draw.
  - Title has priority if the regions overlap.
- Pipeline (2 adv latency):
  - Stage 1 registers rom_addr (code 0x00 outside regions), bit_sel, title_hit and sym_hit.
  - Stage 2 samples font_word[7-bit_sel_q] and registers text_on and text_rgb.
  - Foreground = TITLE_COLOR or SYM_COLOR per hit; black otherwise.
  - text_rgb for pixel (x,y) appears two adv after that pixel was presented.
- frame_start = adv & pix_x==0 & pix_y==0.
- Visibility: vis = (state==BLINK & phase==1) | state==STEADY.
  - When vis is 0, text_on=0 and text_rgb=0. The pipeline still runs.
- FSM:
  - IDLE -> BLINK on adv with show==1 and winner!=00. Latch winner; phase=1; frame_cnt=0; blink_cnt=0.
  - BLINK: on each frame_start, frame_cnt++. When frame_cnt reaches BLINK_FRAMES-1: frame_cnt=0, toggle phase; on a 0->1 toggle, blink_cnt++.
  - BLINK -> STEADY when blink_cnt==BLINK_COUNT and phase==1. If BLINK_COUNT==0, go straight IDLE->STEADY.
  - Any state -> IDLE on adv with show==0. This has priority over every other transition. Latched winner is cleared.
  - winner changes while in BLINK or STEADY are ignored.
  - show high with winner==00 stays in IDLE.
- Counter widths: frame_cnt sized for BLINK_FRAMES; blink_cnt sized for BLINK_COUNT+1. No wrap in STEADY, where the counters are frozen.
- ce low mid-operation: all state frozen and outputs hold their last values.
- Reset mid-blink: immediate return to reset values; no residual pipeline data.

Test Plan:
- Reset asserted during STEADY display -> next clk edge: text_rgb=0, text_on=0, rom_addr=0; after release, stays IDLE until show.
- show=1, winner=01, scan pix(96..127, 64..127) at S=2 -> rom_addr code 0x57. Two ticks later, text_rgb=3'b010 on glyph "1" bits, 0 elsewhere; text_on=3'b010.
- winner=10, pixel (224..255, 192..255) -> code 0x4F, text_rgb=3'b111 on foreground; winner changed to 01 mid-display -> code remains 0x4F.
- winner=11 -> title codes 0x44,0x72,0x61,0x77; symbol cell code 0x00; text_on[0] never 1.
- BLINK_FRAMES=2, BLINK_COUNT=2, frame_start pulses -> visible 2 frames, blank 2, visible 2, blank 2, then steady visible from frame 8 on.
- ce=0 for 10 pixel_ticks mid-frame -> outputs and counters unchanged. show dropped during BLINK -> next adv IDLE, text_on=0 within 2 adv.

Source files
------------

// File: rtl/winner_banner.sv
// winner_banner
// Game-over text layer for the TicTacToe VGA path. It draws a title string
// ("Winner" or "Draw") and, for a decisive game, the winning symbol X or O,
// as magnified 8x16 glyphs fetched from the shared font ROM. The result is
// latched when the game-over screen is requested. The text then blinks for
// BLINK_COUNT on/off cycles of BLINK_FRAMES frames each, and after that it
// is held steady.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   ce          layer enable; when low, the pipeline and the FSM hold
//   pixel_tick  one-cycle strobe per pixel
//   pix_x       current pixel column (10 bits)
//   pix_y       current pixel row (10 bits)
//   show        level, high while the game-over screen is requested
//   winner      00 none, 01 X, 10 O, 11 draw
//   font_word   font ROM row data, valid one pixel_tick after rom_addr
//   rom_addr    {char_code[6:0], glyph_row[3:0]} to the font ROM
//   text_on     {1'b0, title_on, sym_on}, aligned with text_rgb
//   text_rgb    pixel colour
module winner_banner #(
   parameter int         SCALE_LOG2   = 2,
   parameter int         TITLE_ROW    = 1,
   parameter int         TITLE_COL    = 3,
   parameter int         SYM_ROW      = 3,
   parameter int         SYM_COL      = 7,
   parameter int         BLINK_FRAMES = 30,
   parameter int         BLINK_COUNT  = 3,
   parameter logic [2:0] TITLE_COLOR  = 3'b010,
   parameter logic [2:0] SYM_COLOR    = 3'b111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        pixel_tick,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        show,
   input  logic [1:0]  winner,
   input  logic [7:0]  font_word,
   output logic [10:0] rom_addr,
   output logic [2:0]  text_on,
   output logic [2:0]  text_rgb
);

   localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int BCW = (BLINK_COUNT > 0) ? $clog2(BLINK_COUNT + 1) : 1;

   localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);
   localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_COUNT);

   localparam logic [9:0] TITLE_ROW_V = 10'(TITLE_ROW);
   localparam logic [9:0] TITLE_COL_V = 10'(TITLE_COL);
   localparam logic [9:0] TITLE_END_V = 10'(TITLE_COL + 5);
   localparam logic [9:0] SYM_ROW_V   = 10'(SYM_ROW);
   localparam logic [9:0] SYM_COL_V   = 10'(SYM_COL);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLINK  = 2'd1,
      STEADY = 2'd2
   } state_t;

   state_t         state, state_n;
   logic           phase, phase_n;
   logic [FCW-1:0] frame_cnt, frame_cnt_n;
   logic [BCW-1:0] blink_cnt, blink_cnt_n;
   logic [1:0]     win_q, win_n;

   logic       adv;
   logic       frame_start;
   logic       vis;
   logic [9:0] ccol;
   logic [9:0] crow;
   logic [9:0] title_off;
   logic [3:0] glyph_row;
   logic [2:0] bit_sel;
   logic       in_title;
   logic       in_sym;
   logic [6:0] char_code;

   logic [2:0] bit_sel_q;
   logic       title_hit_q;
   logic       sym_hit_q;
   logic       font_bit;
   logic [2:0] fg_color;

   logic       unused_bits;

   // Character codes of the six title cells. The draw string is padded
   // with code 0x00, which the font ROM renders as a blank cell.
   function automatic logic [6:0] title_char(input logic [2:0] k,
                                             input logic       is_draw);
      logic [6:0] code;
      code = 7'h00;
      if (is_draw) begin
         case (k)
            3'd0:    code = 7'h44;
            3'd1:    code = 7'h72;
            3'd2:    code = 7'h61;
            3'd3:    code = 7'h77;
            default: code = 7'h00;
         endcase
      end else begin
         case (k)
            3'd0:    code = 7'h57;
            3'd1:    code = 7'h69;
            3'd2:    code = 7'h6E;
            3'd3:    code = 7'h6E;
            3'd4:    code = 7'h65;
            3'd5:    code = 7'h72;
            default: code = 7'h00;
         endcase
      end
      return code;
   endfunction

   assign adv         = pixel_tick & ce;
   assign frame_start = adv & (pix_x == 10'd0) & (pix_y == 10'd0);
   assign vis         = ((state == BLINK) & phase) | (state == STEADY);

   // The low pixel bits that sit below the magnification only repeat a glyph
   // bit, and the upper bits of the title offset are already covered by the
   // range compare, so they are folded together here to mark them as unused.
   assign unused_bits = ^{pix_x, pix_y, title_off[9:3]};

   // Work out which character cell the current pixel falls in and which
   // glyph row and column of that character it covers. The title cells take
   // priority over the symbol cell if the two overlap. The symbol is shown
   // only for a decisive latched result.
   always_comb begin
      ccol      = pix_x >> (SCALE_LOG2 + 3);
      crow      = pix_y >> (SCALE_LOG2 + 4);
      glyph_row = pix_y[SCALE_LOG2+3 -: 4];
      bit_sel   = pix_x[SCALE_LOG2+2 -: 3];
      title_off = ccol - TITLE_COL_V;
      in_title  = (crow == TITLE_ROW_V) && (ccol >= TITLE_COL_V) &&
                  (ccol <= TITLE_END_V);
      in_sym    = (crow == SYM_ROW_V) && (ccol == SYM_COL_V) &&
                  (win_q[0] ^ win_q[1]) && !in_title;
      char_code = 7'h00;
      if (in_title) begin
         char_code = title_char(title_off[2:0], win_q == 2'b11);
      end else if (in_sym) begin
         char_code = win_q[0] ? 7'h58 : 7'h4F;
      end
   end

   // Stage 1: present the font ROM address for this pixel. The bit select and
   // the region hits travel alongside it so they line up with the returned
   // font row.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_addr    <= '0;
         bit_sel_q   <= '0;
         title_hit_q <= 1'b0;
         sym_hit_q   <= 1'b0;
      end else if (adv) begin
         rom_addr    <= {char_code, glyph_row};
         bit_sel_q   <= bit_sel;
         title_hit_q <= in_title;
         sym_hit_q   <= in_sym;
      end
   end

   // Pick the font bit for this pixel. Bit 7 of a font row is the leftmost
   // glyph column. The foreground colour depends on which region was hit.
   always_comb begin
      font_bit = font_word[3'd7 - bit_sel_q];
      fg_color = 3'b000;
      if (title_hit_q) begin
         fg_color = TITLE_COLOR;
      end else if (sym_hit_q) begin
         fg_color = SYM_COLOR;
      end
   end

   // Stage 2: register the layer outputs. While the blink phase hides the
   // text, both outputs are forced to zero, but the pipeline keeps running so
   // that the text reappears cleanly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         text_on  <= '0;
         text_rgb <= '0;
      end else if (adv) begin
         text_on  <= vis ? {1'b0, title_hit_q, sym_hit_q} : 3'b000;
         text_rgb <= (vis && font_bit) ? fg_color : 3'b000;
      end
   end

   // FSM state register together with the blink counters and the latched
   // result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         phase     <= 1'b0;
         frame_cnt <= '0;
         blink_cnt <= '0;
         win_q     <= 2'b00;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         frame_cnt <= frame_cnt_n;
         blink_cnt <= blink_cnt_n;
         win_q     <= win_n;
      end
   end

   // Next-state logic. Dropping show returns the FSM to IDLE from any state,
   // and this beats every other transition. The result is latched once on
   // entry, so later changes to winner are ignored until the next game over.
   // A blink cycle counts as complete on each off->on phase toggle. Once the
   // last cycle is back in its on phase, the display goes steady and the
   // counters freeze.
   always_comb begin
      state_n     = state;
      phase_n     = phase;
      frame_cnt_n = frame_cnt;
      blink_cnt_n = blink_cnt;
      win_n       = win_q;
      if (adv) begin
         if (!show) begin
            state_n     = IDLE;
            phase_n     = 1'b0;
            frame_cnt_n = '0;
            blink_cnt_n = '0;
            win_n       = 2'b00;
         end else begin
            case (state)
               IDLE: begin
                  if (winner != 2'b00) begin
                     win_n       = winner;
                     phase_n     = 1'b1;
                     frame_cnt_n = '0;
                     blink_cnt_n = '0;
                     state_n     = (BLINK_COUNT == 0) ? STEADY : BLINK;
                  end
               end
               BLINK: begin
                  if ((blink_cnt == BLINK_LAST) && phase) begin
                     state_n = STEADY;
                  end else if (frame_start) begin
                     if (frame_cnt == FRAME_LAST) begin
                        frame_cnt_n = '0;
                        phase_n     = !phase;
                        if (!phase) begin
                           blink_cnt_n = blink_cnt + 1'b1;
                        end
                     end else begin
                        frame_cnt_n = frame_cnt + 1'b1;
                     end
                  end
               end
               STEADY: begin
                  state_n = STEADY;
               end
               default: begin
                  state_n = IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_winner_banner.sv
// tb_winner_banner
// Directed testbench for winner_banner. It runs with SCALE_LOG2=2, which
// gives 32x64 character cells, and with BLINK_FRAMES=2 and BLINK_COUNT=2.
// The font ROM stand-in returns the row {char_code, 1'b1}, so every
// expected pixel bit can be worked out by hand from the character code.
// Frames are simulated by presenting pixel (0,0) directly.
module tb_winner_banner;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        pixel_tick;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        show;
   logic [1:0]  winner;
   logic [7:0]  font_word;
   logic [10:0] rom_addr;
   logic [2:0]  text_on;
   logic [2:0]  text_rgb;

   int checks;
   int failures;

   winner_banner #(
      .SCALE_LOG2   (2),
      .TITLE_ROW    (1),
      .TITLE_COL    (3),
      .SYM_ROW      (3),
      .SYM_COL      (7),
      .BLINK_FRAMES (2),
      .BLINK_COUNT  (2),
      .TITLE_COLOR  (3'b010),
      .SYM_COLOR    (3'b111)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .pixel_tick (pixel_tick),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .show       (show),
      .winner     (winner),
      .font_word  (font_word),
      .rom_addr   (rom_addr),
      .text_on    (text_on),
      .text_rgb   (text_rgb)
   );

   // Font ROM stand-in: the row data is settled before the next pixel_tick
   // edge after the address changes.
   assign font_word = {rom_addr[10:4], 1'b1};

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one pixel for one advance, then settle just past the edge.
   task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
      pix_x      = x;
      pix_y      = y;
      pixel_tick = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [10:0] observed,
                              input logic [10:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One linear sequence of directed steps.
   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      ce         = 1'b1;
      pixel_tick = 1'b0;
      pix_x      = '0;
      pix_y      = '0;
      show       = 1'b0;
      winner     = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_rom", 11'(rom_addr), 11'h000);
      checkOutput("reset_on", 11'(text_on), 11'h000);
      checkOutput("reset_rgb", 11'(text_rgb), 11'h000);
      reset = 1'b0;

      // Winner X: title scan followed by the symbol cell.
      show   = 1'b1;
      winner = 2'b01;
      applyStimulus(10'd10, 10'd10);
      applyStimulus(10'd96, 10'd64);
      checkOutput("x_rom_W", 11'(rom_addr), 11'h570);
      applyStimulus(10'd100, 10'd68);
      checkOutput("x_rom_W_row1", 11'(rom_addr), 11'h571);
      checkOutput("x_rgb_W_b0", 11'(text_rgb), 11'h002);
      checkOutput("x_on_W_b0", 11'(text_on), 11'h002);
      applyStimulus(10'd128, 10'd64);
      checkOutput("x_rom_i", 11'(rom_addr), 11'h690);
      checkOutput("x_rgb_W_b1", 11'(text_rgb), 11'h000);
      checkOutput("x_on_W_b1", 11'(text_on), 11'h002);
      applyStimulus(10'd224, 10'd192);
      checkOutput("x_rom_sym", 11'(rom_addr), 11'h580);
      checkOutput("x_rgb_i", 11'(text_rgb), 11'h002);
      applyStimulus(10'd236, 10'd200);
      checkOutput("x_rom_sym_r2", 11'(rom_addr), 11'h582);
      checkOutput("x_rgb_sym", 11'(text_rgb), 11'h007);
      checkOutput("x_on_sym", 11'(text_on), 11'h001);
      winner = 2'b10;
      applyStimulus(10'd20, 10'd20);
      checkOutput("x_rom_out", 11'(rom_addr), 11'h005);
      checkOutput("x_rgb_sym_b3", 11'(text_rgb), 11'h007);
      applyStimulus(10'd224, 10'd192);
      checkOutput("x_rom_latched", 11'(rom_addr), 11'h580);
      checkOutput("x_on_out", 11'(text_on), 11'h000);

      // Blink schedule: frame 0 is visible, followed by visible 1, blank 2-3,
      // visible 4-5, blank 6-7, and steady from frame 8 on.
      for (int f = 1; f <= 10; f++) begin
         applyStimulus(10'd0, 10'd0);
         applyStimulus(10'd96, 10'd64);
         applyStimulus(10'd20, 10'd20);
         checkOutput($sformatf("blink_on_f%0d", f), 11'(text_on),
                     ((f == 1) || (f == 4) || (f == 5) || (f >= 8)) ?
                     11'h002 : 11'h000);
      end

      // ce low for 10 ticks with show dropped: nothing may move.
      applyStimulus(10'd96, 10'd64);
      applyStimulus(10'd128, 10'd64);
      ce    = 1'b0;
      show  = 1'b0;
      pix_x = 10'd224;
      pix_y = 10'd192;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("ce_rom_hold", 11'(rom_addr), 11'h690);
      checkOutput("ce_rgb_hold", 11'(text_rgb), 11'h002);
      checkOutput("ce_on_hold", 11'(text_on), 11'h002);
      ce   = 1'b1;
      show = 1'b1;
      applyStimulus(10'd20, 10'd20);
      checkOutput("ce_resume_on", 11'(text_on), 11'h002);

      // Dropping show blanks the layer within two advances.
      show = 1'b0;
      applyStimulus(10'd96, 10'd64);
      applyStimulus(10'd96, 10'd64);
      checkOutput("drop_on", 11'(text_on), 11'h000);
      checkOutput("drop_rgb", 11'(text_rgb), 11'h000);

      // Draw: Draw string, blank padding, and no symbol.
      show   = 1'b1;
      winner = 2'b11;
      applyStimulus(10'd10, 10'd10);
      applyStimulus(10'd96, 10'd64);
      checkOutput("d_rom_D", 11'(rom_addr), 11'h440);
      applyStimulus(10'd128, 10'd64);
      checkOutput("d_rom_r", 11'(rom_addr), 11'h720);
      applyStimulus(10'd160, 10'd64);
      checkOutput("d_rom_a", 11'(rom_addr), 11'h610);
      applyStimulus(10'd192, 10'd64);
      checkOutput("d_rom_w", 11'(rom_addr), 11'h770);
      applyStimulus(10'd224, 10'd64);
      checkOutput("d_rom_pad", 11'(rom_addr), 11'h000);
      applyStimulus(10'd224, 10'd192);
      checkOutput("d_rom_sym", 11'(rom_addr), 11'h000);
      checkOutput("d_on_pad", 11'(text_on), 11'h002);
      checkOutput("d_rgb_pad", 11'(text_rgb), 11'h000);
      applyStimulus(10'd20, 10'd20);
      checkOutput("d_on_sym", 11'(text_on), 11'h000);

      // Winner O: the symbol code stays latched when winner changes.
      show = 1'b0;
      applyStimulus(10'd20, 10'd20);
      applyStimulus(10'd20, 10'd20);
      show   = 1'b1;
      winner = 2'b10;
      applyStimulus(10'd10, 10'd10);
      applyStimulus(10'd224, 10'd192);
      checkOutput("o_rom_sym", 11'(rom_addr), 11'h4F0);
      winner = 2'b01;
      applyStimulus(10'd20, 10'd20);
      checkOutput("o_rgb_sym", 11'(text_rgb), 11'h007);
      checkOutput("o_on_sym", 11'(text_on), 11'h001);
      applyStimulus(10'd224, 10'd192);
      checkOutput("o_rom_latched", 11'(rom_addr), 11'h4F0);

      // Run to STEADY with eight frame starts, then apply reset.
      repeat (8) applyStimulus(10'd0, 10'd0);
      applyStimulus(10'd224, 10'd192);
      applyStimulus(10'd20, 10'd20);
      checkOutput("st_rgb_sym", 11'(text_rgb), 11'h007);
      checkOutput("st_on_sym", 11'(text_on), 11'h001);
      reset = 1'b1;
      show  = 1'b0;
      #2;
      checkOutput("rst_rom", 11'(rom_addr), 11'h000);
      checkOutput("rst_on", 11'(text_on), 11'h000);
      checkOutput("rst_rgb", 11'(text_rgb), 11'h000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(10'd224, 10'd192);
      applyStimulus(10'd20, 10'd20);
      checkOutput("rst_idle_on", 11'(text_on), 11'h000);
      show   = 1'b1;
      winner = 2'b01;
      applyStimulus(10'd10, 10'd10);
      applyStimulus(10'd224, 10'd192);
      applyStimulus(10'd20, 10'd20);
      checkOutput("rst_new_on", 11'(text_on), 11'h001);
      checkOutput("rst_new_rgb", 11'(text_rgb), 11'h007);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
